// File: rtl/bus_pkg.sv
// Shared arbiter/mux definitions: state encodings, owner index width, no-owner code.
// Latency: none (types, constants and width helpers only).
// Backpressure: none.
//
// Package bus_pkg: common definitions for bus_arbiter and the shared bus mux.
// The mux uses owner index 0 for "no source" and i+1 for source i, so the
// index width must cover COUNT+1 codes.
package bus_pkg;

    // Arbiter FSM encoding. The fourth code is unused and recovers to idle.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_OWNED = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // Owner index value meaning "nobody drives the bus".
    localparam int OWNER_NONE = 0;

    // Width of the mux owner index: codes 0..COUNT.
    function automatic int owner_w(input int count);
        return $clog2(count + 1);
    endfunction

    // Width of a source index / rotation pointer; at least one bit.
    function automatic int ptr_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester at or above ptr, wrapping to the lowest index.
// Latency: purely combinational.
// Backpressure: none; the result follows req and ptr.
//
// Module rr_pick: the rotation pointer selects where the search starts. Sources
// at or above ptr take priority over sources below it, which gives the wrap.
module rr_pick
    import bus_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int PW    = ptr_w(COUNT)
) (
    input  logic [COUNT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    winner_o,
    output logic             any_req_o
);

    logic          hi_found;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;

    // Scan high-to-low so the last hit kept is the lowest index in each window.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = COUNT - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_idx = PW'(j);
                if (j >= int'(ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(j);
                end
            end
        end
    end

    // No requester at or above ptr means the search wrapped to the lowest one.
    assign winner_o  = hi_found ? hi_idx : lo_idx;
    assign any_req_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter driving the mux one-hot enable, one dead cycle between owners.
// Latency: 1 clk from request sampled to enable; all outputs registered.
// Backpressure: freeze=1 holds every piece of state and output; timeout reads 0.
//
// Module bus_arbiter. Optional feature: define BUS_ARB_TIMEOUT_EN to bound the
// time one source may hold the bus while others wait (MAX_HOLD cycles). Without
// it, ownership lasts until the owner drops its request and timeout stays 0.
// reset_n asserts asynchronously; its release is expected to be synchronous to
// clk (provided by the reset controller upstream).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int  COUNT    = 8,
    parameter int  MAX_HOLD = 16,
    localparam int OW       = owner_w(COUNT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [COUNT-1:0] req,
    input  logic             freeze,
    output logic [COUNT-1:0] enable,
    output logic [OW-1:0]    owner_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int PW = ptr_w(COUNT);

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [COUNT-1:0] enable_q, enable_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    winner;
    logic             any_req;
    logic [PW-1:0]    ptr_next;
    logic [COUNT-1:0] winner_onehot;
    logic             owner_req;
    logic             grant;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
    logic          other_req;
    logic          preempt;
`endif

    rr_pick #(
        .COUNT (COUNT),
        .PW    (PW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Next rotation start is just past the winner; with one source it stays 0.
    assign ptr_next = (winner == PW'(COUNT - 1)) ? '0 : winner + PW'(1);

    // The owner is identified by its enable bit, so no separate index register.
    assign owner_req = |(req & enable_q);

`ifdef BUS_ARB_TIMEOUT_EN
    assign other_req = |(req & ~enable_q);
`endif

    // Decode the arbitration winner into the mux enable pattern.
    always_comb begin
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    // FSM: arbitrate in IDLE/GAP, hold or release in OWNED, nothing moves when frozen.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        enable_d = enable_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        grant    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        preempt  = 1'b0;
`endif
        if (!freeze) begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (any_req) begin
                        state_d  = ST_OWNED;
                        ptr_d    = ptr_next;
                        enable_d = winner_onehot;
                        owner_d  = OW'(winner) + OW'(1);
                        busy_d   = 1'b1;
                        grant    = 1'b1;
                    end else begin
                        // Nothing to grant: a gap with no takers settles to idle.
                        state_d  = ST_IDLE;
                        enable_d = '0;
                        owner_d  = OW'(OWNER_NONE);
                        busy_d   = 1'b0;
                    end
                end
                ST_OWNED: begin
                    if (!owner_req) begin
                        // Owner let go; the bus goes dead for one cycle.
                        state_d  = ST_GAP;
                        enable_d = '0;
                        owner_d  = OW'(OWNER_NONE);
                        busy_d   = 1'b0;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if ((hold_q == HW'(MAX_HOLD - 1)) && other_req) begin
                        // Held too long while others wait; ptr already points past
                        // this owner, so it rejoins the rotation at the back.
                        state_d  = ST_GAP;
                        enable_d = '0;
                        owner_d  = OW'(OWNER_NONE);
                        busy_d   = 1'b0;
                        preempt  = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d  = ST_IDLE;
                    enable_d = '0;
                    owner_d  = OW'(OWNER_NONE);
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Hold counter: restarts on each grant, counts unfrozen owned cycles, saturates.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (!freeze) begin
            if (grant) begin
                hold_d = '0;
            end else if (state_q == ST_OWNED) begin
                if (preempt) begin
                    timeout_d = 1'b1;
                end else if (hold_q != HW'(MAX_HOLD - 1)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // FSM, pointer and registered mux-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            enable_q <= '0;
            owner_q  <= OW'(OWNER_NONE);
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            enable_q <= enable_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
        end
    end

    assign enable    = enable_q;
    assign owner_idx = owner_q;
    assign busy      = busy_q;

    // The mux never sees two enables at once.
    a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(enable_q));

    // Owner index and enable always describe the same source.
    a_owner_match: assert property (@(posedge clk) disable iff (!reset_n)
        ((enable_q == '0) == (owner_q == OW'(OWNER_NONE))) && (busy_q == (enable_q != '0)));

    // Parameter legality.
    a_params: assert property (@(posedge clk) (COUNT >= 1) && (MAX_HOLD >= 2));

endmodule
